cache_ro_line_assoc: RTL
========================

// Module: cache_ro_line_assoc
// PURPOSE
//  Parametrised read-only fully-associative cache, multi-word lines, own refill engine.
//  Sits between processor fetch/load port and system bus master.
//  Single-cycle hit latency; on miss, fetches a whole line as single-word bus requests.
//  Provides invalid-first victim choice, selectable replacement and a whole-cache flush.
// PARAMETERS
//  W_DATA         32  word width, bits; power of two, >= 8
//  W_ADDR         32  byte address width
//  N_ENTRIES      8   number of lines; power of two, >= 2
//  WORDS_PER_LINE 4   words per line; power of two, >= 1
//  REPLACE_LFSR   1   1: pseudorandom victim (16-bit LFSR); 0: round-robin pointer
// PORTS
//  clk           in  1       clock
//  rst_n         in  1       reset, asynchronous, active-low
//  cpu_req_vld   in  1       processor read request valid
//  cpu_req_rdy   out 1       cache can accept request (IDLE state and !flush)
//  cpu_req_addr  in  W_ADDR  byte address; low log2(W_DATA/8) bits ignored
//  cpu_rsp_vld   out 1       one-cycle pulse: cpu_rsp_data valid
//  cpu_rsp_data  out W_DATA  read data
//  flush         in  1       invalidate all lines (single-cycle pulse)
//  mem_req_vld   out 1       bus read request valid
//  mem_req_rdy   in  1       bus accepts request
//  mem_req_addr  out W_ADDR  word-aligned bus read address
//  mem_rsp_vld   in  1       bus read data valid; in-order; no backpressure
//  mem_rsp_data  in  W_DATA  bus read data
// BEHAVIOUR
//  Address split: [tag | line word offset log2(WORDS_PER_LINE) | byte offset log2(W_DATA/8)].
//  Reset: state IDLE, all valid=0, cpu_rsp_vld=0, cpu_rsp_data=0, mem_req_vld=0,
//   mem_req_addr=0, round-robin ptr=0, LFSR=16'h0001 (never all-zero).
//  LFSR taps 16,14,13,4; advances every cycle. Victim bits = LFSR[log2(N_ENTRIES)-1:0].
//  States: IDLE, FILL, RESP.
//  IDLE: cpu_req_rdy=1 unless flush high. Accept = vld & rdy.
//   Tag compare on cpu_req_addr is combinational against all valid lines.
//   Hit: next cycle cpu_rsp_vld=1 with the addressed word; remain IDLE (back-to-back hits OK).
//   Miss: latch address; choose victim = lowest-index invalid line if any, else LFSR/ptr;
//   next cycle: victim valid=0, victim tag written, go FILL.
//   flush in IDLE: all valid=0 next cycle; no request accepted that cycle.
//  FILL: issue WORDS_PER_LINE requests, addresses line base + k*(W_DATA/8), k=0..N-1 ascending.
//   mem_req_vld/addr held stable until mem_req_rdy. Requests may run ahead of responses;
//   separate request and response counters, each wrap-free 0..WORDS_PER_LINE.
//   Each mem_rsp_vld writes word k of victim; the requested word is also captured.
//   mem_rsp_vld with no outstanding request: ignored.
//   After final response: victim valid=1, go RESP. cpu_req_rdy=0 throughout.
//  RESP: cpu_rsp_vld=1 for one cycle with captured word; round-robin ptr increments
//   (mod N_ENTRIES) only on fills that evicted a valid line; go IDLE.
//  flush during FILL/RESP: latched; all valid=0 on entry to IDLE; pending response
//   still delivered with the fetched data.
//  No duplicate tags: fill occurs only on miss, so at most one line matches.
//  Async reset mid-FILL: abandons refill, all lines invalid; bus must also be reset.
//  cpu_rsp_vld never asserted except as above; cpu_rsp_data holds last value otherwise.
// TESTING
//  Cold read 0x100 (WORDS_PER_LINE=4, W_DATA=32) -> bus reads 0x100,0x104,0x108,0x10C; rsp = word 0x100.
//  Then read 0x108 -> rsp_vld exactly 1 cycle after accept, no bus traffic, data = bus word 2.
//  Fill 8 distinct lines, then 9th miss, REPLACE_LFSR=0 -> line 0 evicted; re-read line 0 misses.
//  flush pulse in IDLE, then read 0x108 -> miss, full 4-word refill issued.
//  flush asserted mid-FILL -> response still returned; following read of same line misses.
//  mem_req_rdy low 5 cycles on 2nd request -> mem_req_addr stable at 0x104; reset mid-FILL -> rdy=1, all miss.

Source files
------------

// File: rtl/cache_ro_line_assoc.sv
// rtl/cache_ro_line_assoc.sv - read-only fully-associative line cache with in-order refill engine
module cache_ro_line_assoc #(
    parameter int W_DATA         = 32,
    parameter int W_ADDR         = 32,
    parameter int N_ENTRIES      = 8,
    parameter int WORDS_PER_LINE = 4,
    parameter bit REPLACE_LFSR   = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req_vld,
    output logic              cpu_req_rdy,
    input  logic [W_ADDR-1:0] cpu_req_addr,
    output logic              cpu_rsp_vld,
    output logic [W_DATA-1:0] cpu_rsp_data,
    input  logic              flush,
    output logic              mem_req_vld,
    input  logic              mem_req_rdy,
    output logic [W_ADDR-1:0] mem_req_addr,
    input  logic              mem_rsp_vld,
    input  logic [W_DATA-1:0] mem_rsp_data
);

    localparam int BYTES      = W_DATA / 8;
    localparam int OFF_W      = $clog2(BYTES);
    localparam int WORD_W     = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;
    localparam int LINE_OFF_W = OFF_W + $clog2(WORDS_PER_LINE);
    localparam int TAG_W      = W_ADDR - LINE_OFF_W;
    localparam int IDX_W      = $clog2(N_ENTRIES);
    localparam int CNT_W      = $clog2(WORDS_PER_LINE) + 1;
    localparam logic [W_ADDR-1:0] LINE_MASK = {W_ADDR{1'b1}} << LINE_OFF_W;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_FILL = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]          state_q;
    logic [N_ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]    tag_q [N_ENTRIES];
    logic [W_DATA-1:0]   data_q [N_ENTRIES][WORDS_PER_LINE];
    logic [IDX_W-1:0]    victim_q;
    logic [IDX_W-1:0]    ptr_q;
    logic                evict_q;
    logic                flush_pend_q;
    logic [WORD_W-1:0]   want_q;
    logic [CNT_W-1:0]    req_cnt_q;
    logic [CNT_W-1:0]    rsp_cnt_q;
    logic [W_DATA-1:0]   cap_q;
    logic [15:0]         lfsr_q;

    function automatic logic [WORD_W-1:0] word_of(input logic [W_ADDR-1:0] a);
        if (WORDS_PER_LINE > 1) return a[OFF_W +: WORD_W];
        else                    return '0;
    endfunction

    logic [TAG_W-1:0]  req_tag;
    logic [WORD_W-1:0] req_word;
    logic              hit;
    logic [IDX_W-1:0]  hit_idx;
    logic              inv_found;
    logic [IDX_W-1:0]  inv_idx;
    logic [IDX_W-1:0]  victim;
    logic              accept;
    logic              rsp_take;
    logic              rsp_last;
    logic [WORD_W-1:0] rsp_word;
    logic [W_DATA-1:0] cap_next;
    logic              lfsr_fb;

    assign req_tag     = cpu_req_addr[W_ADDR-1 -: TAG_W];
    assign req_word    = word_of(cpu_req_addr);
    assign cpu_req_rdy = (state_q == S_IDLE) && !flush;
    assign accept      = cpu_req_vld && cpu_req_rdy;
    assign lfsr_fb     = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[3];

    // Tags are unique (fill only on miss), so at most one line matches.
    always_comb begin
        hit       = 1'b0;
        hit_idx   = '0;
        inv_found = 1'b0;
        inv_idx   = '0;
        for (int i = 0; i < N_ENTRIES; i++) begin
            if (valid_q[i] && tag_q[i] == req_tag) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
        for (int i = N_ENTRIES - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                inv_found = 1'b1;
                inv_idx   = IDX_W'(i);
            end
        end
    end

    assign victim = inv_found    ? inv_idx :
                    REPLACE_LFSR ? lfsr_q[IDX_W-1:0] : ptr_q;

    // Responses only count while one is outstanding; strays are dropped.
    assign rsp_take = (state_q == S_FILL) && mem_rsp_vld && (rsp_cnt_q < req_cnt_q);
    assign rsp_last = rsp_take && (rsp_cnt_q == CNT_W'(WORDS_PER_LINE - 1));
    assign rsp_word = rsp_cnt_q[WORD_W-1:0];
    assign cap_next = (want_q == rsp_word) ? mem_rsp_data : cap_q;

    always_ff @(posedge clk) begin
        if (rsp_take) data_q[victim_q][rsp_word] <= mem_rsp_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            valid_q      <= '0;
            for (int i = 0; i < N_ENTRIES; i++) tag_q[i] <= '0;
            victim_q     <= '0;
            ptr_q        <= '0;
            evict_q      <= 1'b0;
            flush_pend_q <= 1'b0;
            want_q       <= '0;
            req_cnt_q    <= '0;
            rsp_cnt_q    <= '0;
            cap_q        <= '0;
            lfsr_q       <= 16'h0001;
            cpu_rsp_vld  <= 1'b0;
            cpu_rsp_data <= '0;
            mem_req_vld  <= 1'b0;
            mem_req_addr <= '0;
        end else begin
            lfsr_q      <= {lfsr_q[14:0], lfsr_fb};
            cpu_rsp_vld <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (flush) begin
                        valid_q <= '0;
                    end else if (accept) begin
                        if (hit) begin
                            cpu_rsp_vld  <= 1'b1;
                            cpu_rsp_data <= data_q[hit_idx][req_word];
                        end else begin
                            victim_q        <= victim;
                            evict_q         <= valid_q[victim];
                            valid_q[victim] <= 1'b0;
                            tag_q[victim]   <= req_tag;
                            want_q          <= req_word;
                            req_cnt_q       <= '0;
                            rsp_cnt_q       <= '0;
                            flush_pend_q    <= 1'b0;
                            mem_req_vld     <= 1'b1;
                            mem_req_addr    <= cpu_req_addr & LINE_MASK;
                            state_q         <= S_FILL;
                        end
                    end
                end
                S_FILL: begin
                    if (flush) flush_pend_q <= 1'b1;
                    if (mem_req_vld && mem_req_rdy) begin
                        req_cnt_q <= req_cnt_q + 1'b1;
                        if (req_cnt_q == CNT_W'(WORDS_PER_LINE - 1)) mem_req_vld <= 1'b0;
                        else mem_req_addr <= mem_req_addr + W_ADDR'(BYTES);
                    end
                    if (rsp_take) begin
                        rsp_cnt_q <= rsp_cnt_q + 1'b1;
                        cap_q     <= cap_next;
                    end
                    if (rsp_last) begin
                        valid_q[victim_q] <= 1'b1;
                        cpu_rsp_vld       <= 1'b1;
                        cpu_rsp_data      <= cap_next;
                        state_q           <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (evict_q) ptr_q <= ptr_q + 1'b1;
                    if (flush || flush_pend_q) valid_q <= '0;
                    flush_pend_q <= 1'b0;
                    state_q      <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
